// File: rtl/quad_decoder_pkg.sv
// quad_decoder_pkg -- shared types and constants for the quadrature decoder.
//   ab_t       : 2-bit encoder state, packed as {B,A}
//   dec_t      : result of decoding one {prev,curr} state pair
//   DECODE_TBL : {prev,curr} -> DEC_NONE / DEC_FWD / DEC_REV / DEC_ERR
//   SPEED_W    : width of the signed SPEED output
package quad_decoder_pkg;

   typedef logic [1:0] ab_t;

   typedef enum logic [1:0] {
      DEC_NONE = 2'd0,
      DEC_FWD  = 2'd1,
      DEC_REV  = 2'd2,
      DEC_ERR  = 2'd3
   } dec_t;

   localparam int SPEED_W = 16;

   // Forward is {B,A} 01 -> 11 -> 10 -> 00 -> 01. Entries run from index 15
   // ({prev,curr} = 11_11) down to index 0 (00_00).
   localparam logic [15:0][1:0] DECODE_TBL = {
      2'd0, 2'd1, 2'd2, 2'd3,   // prev 11: curr 11,10,01,00
      2'd2, 2'd0, 2'd3, 2'd1,   // prev 10
      2'd1, 2'd3, 2'd0, 2'd2,   // prev 01
      2'd3, 2'd2, 2'd1, 2'd0    // prev 00
   };

   function automatic dec_t decode(input ab_t prev, input ab_t curr);
      return dec_t'(DECODE_TBL[{prev, curr}]);
   endfunction

endpackage

// File: rtl/quad_decoder_filter.sv
// quad_decoder_filter -- 2-flop synchronizer plus optional glitch filter for
// the encoder phases. Build with QUAD_DECODER_FILTER_EN defined to add the
// stability filter; otherwise the synchronized value passes straight through.
//   clk, rst : system clock, synchronous active-high reset
//   a, b     : asynchronous encoder phases
//   state    : accepted {B,A} state
//   valid    : high once state carries a real sample (not reset fill)
module quad_decoder_filter
   import quad_decoder_pkg::*;
`ifdef QUAD_DECODER_FILTER_EN
#(
   parameter int FILTER_LEN = 4
)
`endif
(
   input  logic clk,
   input  logic rst,
   input  logic a,
   input  logic b,
   output ab_t  state,
   output logic valid
);

   ab_t        sync1, sync2;
   logic [1:0] fill;   // tracks when sync2 holds a post-reset sample

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
         fill  <= '0;
      end else begin
         sync1 <= {b, a};
         sync2 <= sync1;
         fill  <= {fill[0], 1'b1};
      end
   end

`ifdef QUAD_DECODER_FILTER_EN
   localparam logic [3:0] FLEN = 4'(FILTER_LEN);

   ab_t        cand;      // previous synchronized sample
   ab_t        acc;
   logic       acc_vld;
   logic [3:0] run, run_n;

   // run_n = length of the current streak of identical samples, saturating.
   always_comb begin
      run_n = 4'd1;
      if (sync2 == cand) run_n = (run == 4'd15) ? run : run + 4'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cand    <= '0;
         run     <= '0;
         acc     <= '0;
         acc_vld <= 1'b0;
      end else if (fill[1]) begin
         cand <= sync2;
         run  <= run_n;
         if (run_n >= FLEN) begin
            acc     <= sync2;
            acc_vld <= 1'b1;
         end
      end
   end

   assign state = acc;
   assign valid = acc_vld;
`else
   assign state = sync2;
   assign valid = fill[1];
`endif

endmodule

// File: rtl/quad_decoder.sv
// quad_decoder -- quadrature encoder decoder with position, direction,
// sticky illegal-transition flag and windowed speed measurement.
// Optional input glitch filter: define QUAD_DECODER_FILTER_EN.
//   CLOCK, RESET : system clock, synchronous active-high reset
//   A, B         : asynchronous encoder phases
//   CLEAR        : synchronous clear of POSITION and ERROR
//   POSITION     : signed 32-bit accumulated count (wraps)
//   STEP, DIR    : step pulse and direction of last valid step (1 = fwd)
//   ERROR        : sticky illegal-transition flag
//   SPEED        : saturated net steps of the last 2^WINDOW_BITS-clock window
//   SPEED_VALID  : one-cycle pulse when SPEED updates
module quad_decoder
   import quad_decoder_pkg::*;
#(
   parameter int FILTER_LEN  = 4,
   parameter int WINDOW_BITS = 16
)(
   input  logic                      CLOCK,
   input  logic                      RESET,
   input  logic                      A,
   input  logic                      B,
   input  logic                      CLEAR,
   output logic signed [31:0]        POSITION,
   output logic                      STEP,
   output logic                      DIR,
   output logic                      ERROR,
   output logic signed [SPEED_W-1:0] SPEED,
   output logic                      SPEED_VALID
);

   if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_filter_len
      $error("quad_decoder: FILTER_LEN must be 1..15");
   end
   if (WINDOW_BITS < 4 || WINDOW_BITS > 24) begin : g_bad_window_bits
      $error("quad_decoder: WINDOW_BITS must be 4..24");
   end

   // Accumulator wide enough for a full window of steps and the clamp limits.
   localparam int AW = (WINDOW_BITS + 2 > SPEED_W + 1) ? WINDOW_BITS + 2 : SPEED_W + 1;
   localparam logic signed [AW-1:0] SPD_MAX = AW'((2 ** (SPEED_W - 1)) - 1);
   localparam logic signed [AW-1:0] SPD_MIN = -SPD_MAX - AW'(1);

   ab_t  cur, ref_q;
   logic cur_vld, loaded;
   dec_t dec;
   logic step_fwd, step_rev, step_bad;

   logic signed [31:0]   pos_q;
   logic [WINDOW_BITS-1:0] win_cnt;
   logic signed [AW-1:0] accum, accum_n;

   quad_decoder_filter
`ifdef QUAD_DECODER_FILTER_EN
      #(.FILTER_LEN(FILTER_LEN))
`endif
   u_filter (
      .clk   (CLOCK),
      .rst   (RESET),
      .a     (A),
      .b     (B),
      .state (cur),
      .valid (cur_vld)
   );

   // Nothing counts until the reference state has been loaded once.
   always_comb begin
      dec      = decode(ref_q, cur);
      step_fwd = loaded && (dec == DEC_FWD);
      step_rev = loaded && (dec == DEC_REV);
      step_bad = loaded && (dec == DEC_ERR);
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         ref_q  <= '0;
         loaded <= 1'b0;
         pos_q  <= '0;
         STEP   <= 1'b0;
         DIR    <= 1'b0;
         ERROR  <= 1'b0;
      end else begin
         if (cur_vld) begin
            ref_q  <= cur;
            loaded <= 1'b1;
         end
         STEP <= step_fwd | step_rev;
         if (step_fwd)      DIR <= 1'b1;
         else if (step_rev) DIR <= 1'b0;
         // CLEAR wins over a coincident step; ERROR set wins over CLEAR.
         if (CLEAR)         pos_q <= '0;
         else if (step_fwd) pos_q <= pos_q + 32'sd1;
         else if (step_rev) pos_q <= pos_q - 32'sd1;
         if (step_bad)      ERROR <= 1'b1;
         else if (CLEAR)    ERROR <= 1'b0;
      end
   end

   assign POSITION = pos_q;

   // Step landing on the terminal window cycle is folded into this window.
   always_comb begin
      accum_n = accum;
      if (step_fwd)      accum_n = accum + AW'(1);
      else if (step_rev) accum_n = accum - AW'(1);
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         win_cnt     <= '0;
         accum       <= '0;
         SPEED       <= '0;
         SPEED_VALID <= 1'b0;
      end else begin
         win_cnt     <= win_cnt + WINDOW_BITS'(1);
         SPEED_VALID <= 1'b0;
         if (&win_cnt) begin
            accum       <= '0;
            SPEED_VALID <= 1'b1;
            if (accum_n > SPD_MAX)      SPEED <= SPD_MAX[SPEED_W-1:0];
            else if (accum_n < SPD_MIN) SPEED <= SPD_MIN[SPEED_W-1:0];
            else                        SPEED <= accum_n[SPEED_W-1:0];
         end else begin
            accum <= accum_n;
         end
      end
   end

endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder -- directed self-checking bench for quad_decoder
// (FILTER_LEN=4, WINDOW_BITS=8). Works with or without QUAD_DECODER_FILTER_EN.
module tb_quad_decoder;

   localparam int FLEN  = 4;
   localparam int WBITS = 8;
`ifdef QUAD_DECODER_FILTER_EN
   localparam int LAT = 3 + FLEN;
`else
   localparam int LAT = 3;
`endif

   logic               CLOCK = 1'b0;
   logic               RESET, A, B, CLEAR;
   logic signed [31:0] POSITION;
   logic               STEP, DIR, ERROR, SPEED_VALID;
   logic signed [15:0] SPEED;

   int n_chk = 0;
   int n_err = 0;
   int step_cnt = 0;

   quad_decoder #(.FILTER_LEN(FLEN), .WINDOW_BITS(WBITS)) dut (
      .CLOCK       (CLOCK),
      .RESET       (RESET),
      .A           (A),
      .B           (B),
      .CLEAR       (CLEAR),
      .POSITION    (POSITION),
      .STEP        (STEP),
      .DIR         (DIR),
      .ERROR       (ERROR),
      .SPEED       (SPEED),
      .SPEED_VALID (SPEED_VALID)
   );

   always #5 CLOCK = ~CLOCK;

   always @(posedge CLOCK) begin
      #1;
      if (STEP === 1'b1) step_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge CLOCK);
   endtask

   task automatic set_ab(input logic [1:0] v);
      {B, A} = v;
   endtask

   task automatic move(input logic [1:0] v);
      set_ab(v);
      cyc(20);
   endtask

   task automatic wait_spd(input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         cyc(1);
         if (SPEED_VALID === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk(tag, 32'd0, 32'd1);
   endtask

   initial begin
      int sc0;
      logic [1:0] rev_seq [5];
      rev_seq = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10};

      RESET = 1'b1; CLEAR = 1'b0; set_ab(2'b00);
      cyc(5);
      chk("rst_pos",   POSITION,   32'd0);
      chk("rst_step",  STEP,       32'd0);
      chk("rst_dir",   DIR,        32'd0);
      chk("rst_err",   ERROR,      32'd0);
      chk("rst_speed", {{16{SPEED[15]}}, SPEED}, 32'd0);
      chk("rst_svld",  SPEED_VALID, 32'd0);
      RESET = 1'b0;
      cyc(10);

      // eight forward steps
      sc0 = step_cnt;
      for (int k = 0; k < 2; k++) begin
         move(2'b01); move(2'b11); move(2'b10); move(2'b00);
      end
      chk("fwd_pos",   POSITION,       32'd8);
      chk("fwd_dir",   DIR,            32'd1);
      chk("fwd_steps", step_cnt - sc0, 32'd8);
      chk("fwd_err",   ERROR,          32'd0);

      // latency of one forward step
      set_ab(2'b01);
      cyc(LAT - 1);
      chk("lat_pos_early",  POSITION, 32'd8);
      chk("lat_step_early", STEP,     32'd0);
      cyc(1);
      chk("lat_pos",  POSITION, 32'd9);
      chk("lat_step", STEP,     32'd1);
      cyc(1);
      chk("lat_step_pulse", STEP, 32'd0);
      cyc(18);
      move(2'b00);
      chk("rev_pos", POSITION, 32'd8);
      chk("rev_dir", DIR,      32'd0);

      // two-cycle glitch on A
      sc0 = step_cnt;
      set_ab(2'b01); cyc(2); set_ab(2'b00); cyc(20);
`ifdef QUAD_DECODER_FILTER_EN
      chk("glitch_steps", step_cnt - sc0, 32'd0);
`else
      chk("glitch_steps", step_cnt - sc0, 32'd2);
`endif
      chk("glitch_pos", POSITION, 32'd8);
      sc0 = step_cnt;
      set_ab(2'b01); cyc(10);
      chk("hold_steps", step_cnt - sc0, 32'd1);
      chk("hold_pos",   POSITION,       32'd9);
      move(2'b00);

      // wrap around 0x7FFFFFFF <-> 0x80000000
      force dut.pos_q = 32'sh7FFF_FFFF;
      cyc(1);
      release dut.pos_q;
      cyc(1);
      chk("pre_wrap", POSITION, 32'h7FFF_FFFF);
      move(2'b01);
      chk("wrap_fwd", POSITION, 32'h8000_0000);
      move(2'b00);
      chk("wrap_rev", POSITION, 32'h7FFF_FFFF);

      // illegal jump 01 -> 10, then CLEAR
      move(2'b01);
      sc0 = step_cnt;
      move(2'b10);
      chk("ill_err",   ERROR,          32'd1);
      chk("ill_pos",   POSITION,       32'h8000_0000);
      chk("ill_steps", step_cnt - sc0, 32'd0);
      chk("ill_dir",   DIR,            32'd1);
      CLEAR = 1'b1; cyc(1); CLEAR = 1'b0;
      chk("clr_err", ERROR,    32'd0);
      chk("clr_pos", POSITION, 32'd0);
      cyc(5);

      // CLEAR on the same edge as a valid step
      move(2'b00);
      move(2'b01);
      chk("pre_clr_pos", POSITION, 32'd2);
      set_ab(2'b11);
      cyc(LAT - 1);
      CLEAR = 1'b1; cyc(1); CLEAR = 1'b0;
      chk("clrstep_pos",  POSITION, 32'd0);
      chk("clrstep_step", STEP,     32'd1);
      chk("clrstep_dir",  DIR,      32'd1);
      cyc(20);

      // CLEAR on the same edge as an illegal transition (11 -> 00)
      set_ab(2'b00);
      cyc(LAT - 1);
      CLEAR = 1'b1; cyc(1); CLEAR = 1'b0;
      chk("clrill_err",  ERROR,    32'd1);
      chk("clrill_pos",  POSITION, 32'd0);
      chk("clrill_step", STEP,     32'd0);
      cyc(20);

      // speed window: five reverse steps in one window, then an idle window
      wait_spd("spd_sync_timeout");
      for (int k = 0; k < 5; k++) move(rev_seq[k]);
      wait_spd("spd_win1_timeout");
      chk("spd_rev5", {{16{SPEED[15]}}, SPEED}, 32'hFFFF_FFFB);
      cyc(1);
      chk("spd_vld_pulse", SPEED_VALID, 32'd0);
      chk("spd_hold", {{16{SPEED[15]}}, SPEED}, 32'hFFFF_FFFB);
      wait_spd("spd_win2_timeout");
      chk("spd_idle", {{16{SPEED[15]}}, SPEED}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 The module SHALL have parameter FILTER_LEN, default 4: consecutive identical synchronized samples required before an A/B change is accepted (range 1..15).
REQ-002 The module SHALL have parameter WINDOW_BITS, default 16: the speed sample window is 2^WINDOW_BITS clocks (range 4..24).
REQ-003 The module SHALL have port CLOCK, input, 1: single system clock; all logic is on its rising edge.
REQ-004 The module SHALL have port RESET, input, 1: synchronous, active-high reset.
REQ-005 The module SHALL have ports A and B, input, 1 each: asynchronous encoder phases.
REQ-006 The module SHALL have port CLEAR, input, 1: synchronous clear of POSITION and ERROR.
REQ-007 The module SHALL have port POSITION, output, 32, signed: accumulated quadrature count.
REQ-008 The module SHALL have port STEP, output, 1: one-cycle pulse per accepted valid transition.
REQ-009 The module SHALL have port DIR, output, 1: direction of the last valid step (1 = forward).
REQ-010 The module SHALL have port ERROR, output, 1: sticky illegal-transition flag.
REQ-011 The module SHALL have port SPEED, output, 16, signed: net steps counted in the last completed window.
REQ-012 The module SHALL have port SPEED_VALID, output, 1: one-cycle pulse when SPEED updates.

Function
REQ-013 Each of A and B SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Forward SHALL be the {B,A} sequence 01->11->10->00->01; each forward step adds +1 to POSITION; each reverse step adds -1.
REQ-015 A single-bit change of the accepted state SHALL be a valid step: POSITION updates, STEP pulses, and DIR is set, all in the same cycle.
REQ-016 A change of both bits in one accepted update SHALL count nothing, pulse no STEP, leave DIR unchanged, and set ERROR.
REQ-017 With filtering disabled, POSITION SHALL update on the 3rd rising edge after the first edge that samples the new A/B value.
REQ-018 POSITION SHALL wrap modulo 2^32 (0x7FFFFFFF + 1 = 0x80000000) with no saturation.
REQ-019 CLEAR SHALL set POSITION to 0 on the next edge; a step in the same cycle is discarded, and STEP still pulses.
REQ-020 CLEAR SHALL clear ERROR; if an illegal transition occurs in the same cycle, ERROR SHALL end set.
REQ-021 A free-running window counter of WINDOW_BITS bits SHALL accumulate net steps, including the step on the terminal cycle.
REQ-022 At window wrap, SPEED SHALL load the accumulator saturated to [-32768, 32767], SPEED_VALID SHALL pulse, and the accumulator SHALL restart at 0.
REQ-023 CLEAR SHALL NOT affect the window counter, the accumulator, or SPEED.

Reset
REQ-024 RESET SHALL zero POSITION, STEP, DIR, ERROR, SPEED, SPEED_VALID, the window counter, the accumulator, the synchronizers and the filter.
REQ-025 After reset, the first accepted A/B state SHALL load the reference state without counting or flagging an error.
REQ-026 RESET SHALL override CLEAR and any transition in progress.

Configuration
REQ-027 With macro QUAD_DECODER_FILTER_EN defined, an A/B change SHALL be accepted only after FILTER_LEN identical consecutive synchronized samples, adding FILTER_LEN cycles of latency; shorter pulses are ignored.
REQ-028 Without QUAD_DECODER_FILTER_EN, the synchronized value SHALL be accepted every cycle, FILTER_LEN SHALL be ignored, and no filter logic SHALL be generated.

Structure
REQ-029 Package quad_decoder_pkg SHALL hold the 2-bit state type, the transition-decode table constant ({prev,curr} -> +1/-1/0/err), and the SPEED width constant.
REQ-030 Synchronization and filtering SHALL be implemented in sub-module quad_decoder_filter (per-bit sync, stability counter, accepted-state output).

Verification
REQ-031 Bench SHALL apply RESET, then 8 forward steps of {B,A} 01,11,10,00,... every 20 cycles -> POSITION=8, DIR=1, 8 STEP pulses, ERROR=0.
REQ-032 Bench SHALL preload POSITION=0x7FFFFFFF via forward steps or force, then apply one forward step -> POSITION=0x80000000; one reverse step -> 0x7FFFFFFF.
REQ-033 Bench SHALL jump {B,A} 01->10 -> ERROR=1, POSITION unchanged, no STEP; then CLEAR -> ERROR=0, POSITION=0.
REQ-034 Bench SHALL, with QUAD_DECODER_FILTER_EN and FILTER_LEN=4, apply a 2-cycle glitch on A -> no STEP; then hold the change 10 cycles -> exactly one STEP.
REQ-035 Bench SHALL, with WINDOW_BITS=8, apply 5 reverse steps inside one window -> SPEED=-5 with SPEED_VALID for one cycle at the wrap; an idle next window -> SPEED=0.
REQ-036 Bench SHALL assert CLEAR in the same cycle as a valid step -> POSITION=0 and STEP=1.
